// File: rtl/dlfloat_link_master.sv
// Host-side link master for the DLFloat MAC pin interface: operand FIFO, a/b-word bus
// serialiser, and result byte reassembly with issue tagging. Optional macro LINK_PERF_CNT_EN.
module dlfloat_link_master #(
    parameter int DEPTH     = 4,
    parameter int RES_LAT   = 6,
    parameter int RX_PHASE0 = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_a,
    input  logic [15:0]            in_b,
    output logic [15:0]            link_data,
    output logic                   link_phase,
    input  logic [7:0]             res_byte,
    output logic                   res_valid,
    output logic [15:0]            res_data,
    output logic                   res_tag,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef LINK_PERF_CNT_EN
    ,
    output logic [15:0]            pair_cnt,
    output logic [15:0]            idle_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } tx_state_t;

    // Operand FIFO storage and pointers (DEPTH is a power of two, so pointers wrap naturally).
    logic [15:0]   r_mem_a [DEPTH];
    logic [15:0]   r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [15:0]   r_link_data;
    logic          r_link_phase;
    logic [15:0]   r_b_hold;
    logic          r_pair_active;
    logic [RES_LAT:0] r_tag_dly;

    logic          r_rx_phase;
    logic [7:0]    r_low_hold;
    logic [15:0]   r_res_data;
    logic          r_res_valid;
    logic          r_res_tag;
    logic          r_pending;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_tag_hit;
    logic [15:0]   w_link_nxt;
    logic [15:0]   w_b_hold_nxt;
    logic          w_pair_act_nxt;

    // Handshake: a pair transfers on any clock edge where in_valid && in_ready. in_ready
    // depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_full   = (r_count == LW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign in_ready = !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // TX phase runs free from reset so it stays locked to the MAC's own capture phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PH_A;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = PH_A;
        w_pop          = 1'b0;
        w_issue        = 1'b0;
        w_link_nxt     = 16'h0000;
        w_b_hold_nxt   = r_b_hold;
        w_pair_act_nxt = r_pair_active;
        case (r_state)
            PH_A: begin
                w_state_nxt = PH_B;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_link_nxt     = r_mem_a[r_rd_ptr];
                    w_b_hold_nxt   = r_mem_b[r_rd_ptr];
                    w_pair_act_nxt = 1'b1;
                end else begin
                    w_b_hold_nxt   = 16'h0000;
                    w_pair_act_nxt = 1'b0;
                end
            end
            PH_B: begin
                w_state_nxt = PH_A;
                w_link_nxt  = r_b_hold;
                w_issue     = r_pair_active;
            end
            default: w_state_nxt = PH_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_data   <= 16'h0000;
            r_link_phase  <= 1'b0;
            r_b_hold      <= 16'h0000;
            r_pair_active <= 1'b0;
        end else begin
            r_link_data   <= w_link_nxt;
            r_link_phase  <= (r_state == PH_B);
            r_b_hold      <= w_b_hold_nxt;
            r_pair_active <= w_pair_act_nxt;
        end
    end

    // Bit 0 lines up with the b-word on the bus; bit RES_LAT with the first result byte it affects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tag_dly <= '0;
        else     r_tag_dly <= {r_tag_dly[RES_LAT-1:0], w_issue};
    end

    assign w_tag_hit = r_tag_dly[RES_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_phase  <= 1'(RX_PHASE0);
            r_low_hold  <= 8'h00;
            r_res_data  <= 16'h0000;
            r_res_valid <= 1'b0;
            r_res_tag   <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_rx_phase <= ~r_rx_phase;
            if (r_rx_phase) begin
                r_res_data  <= {res_byte, r_low_hold};
                r_res_valid <= 1'b1;
                r_res_tag   <= r_pending | w_tag_hit;
                r_pending   <= 1'b0;
            end else begin
                r_low_hold  <= res_byte;
                r_res_valid <= 1'b0;
                r_res_tag   <= 1'b0;
                r_pending   <= r_pending | w_tag_hit;
            end
        end
    end

    assign link_data  = r_link_data;
    assign link_phase = r_link_phase;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_tag    = r_res_tag;
    assign fifo_level = r_count;

`ifdef LINK_PERF_CNT_EN
    logic [15:0] r_pair_cnt;
    logic [15:0] r_idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair_cnt <= 16'h0000;
            r_idle_cnt <= 16'h0000;
        end else if (r_state == PH_A) begin
            if (w_pop) r_pair_cnt <= r_pair_cnt + 16'd1;
            else       r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign pair_cnt = r_pair_cnt;
    assign idle_cnt = r_idle_cnt;
`endif

endmodule

// File: tb/tb_dlfloat_link_master.sv
// Directed bench for dlfloat_link_master: idle framing, single pair + tag timing,
// FIFO backpressure, mid-pair reset, post-reset pairs (and perf counters when enabled).
module tb_dlfloat_link_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic [7:0]  res_byte = 8'h00;
  logic        in_ready;
  logic [15:0] link_data;
  logic        link_phase;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_tag;
  logic [2:0]  fifo_level;
`ifdef LINK_PERF_CNT_EN
  logic [15:0] pair_cnt;
  logic [15:0] idle_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  logic [7:0]  rx_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [15:0] rx_words [3] = '{16'h2211, 16'h4433, 16'h6655};
  int          lvl_tab [19] = '{0, 1, 2, 2, 3, 3, 4, 3, 4, 3, 4, 3, 3, 2, 2, 1, 1, 0, 0};

  dlfloat_link_master #(.DEPTH(4), .RES_LAT(6), .RX_PHASE0(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .link_data  (link_data),
    .link_phase (link_phase),
    .res_byte   (res_byte),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .fifo_level (fifo_level)
`ifdef LINK_PERF_CNT_EN
    ,
    .pair_cnt   (pair_cnt),
    .idle_cnt   (idle_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input int k, input logic exp_tag);
    check($sformatf("res_valid c%0d", k), 32'(res_valid), 32'(k % 2 == 0));
    check($sformatf("res_tag c%0d", k), 32'(res_tag), 32'(exp_tag));
  endtask

  initial begin
    logic [15:0] exp_w;
    int idx;
    logic acc;

    repeat (3) @(posedge clk);
    #1;
    check("rst link_data", 32'(link_data), 32'h0);
    check("rst link_phase", 32'(link_phase), 32'h0);
    check("rst res_valid", 32'(res_valid), 32'h0);
    check("rst res_data", 32'(res_data), 32'h0);
    check("rst res_tag", 32'(res_tag), 32'h0);
    check("rst fifo_level", 32'(fifo_level), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    res_byte = rx_bytes[0];
    step();

    // idle: zero pairs, phase toggling, byte reassembly
    for (int k = 1; k < 8; k++) begin
      check($sformatf("idle link_data c%0d", k), 32'(link_data), 32'h0);
      check($sformatf("idle link_phase c%0d", k), 32'(link_phase), 32'(k % 2 == 0));
      check($sformatf("idle in_ready c%0d", k), 32'(in_ready), 32'h1);
      check($sformatf("idle fifo_level c%0d", k), 32'(fifo_level), 32'h0);
      check_rx(k, 1'b0);
      if (k % 2 == 0) check($sformatf("idle res_data c%0d", k), 32'(res_data), 32'(rx_words[k/2-1]));
      res_byte = rx_bytes[k];
      step();
    end

    // single pair pushed in PH_A into an empty FIFO; MAC result 0x4000 appears RES_LAT after b-word
    for (int k = 8; k < 22; k++) begin
      exp_w = (k == 11) ? 16'h3E00 : (k == 12) ? 16'h4000 : 16'h0000;
      check($sformatf("pair link_data c%0d", k), 32'(link_data), 32'(exp_w));
      check($sformatf("pair link_phase c%0d", k), 32'(link_phase), 32'(k % 2 == 0));
      check($sformatf("pair fifo_level c%0d", k), 32'(fifo_level), (k == 9 || k == 10) ? 32'h1 : 32'h0);
      check_rx(k, k == 20);
      if (k % 2 == 0) begin
        exp_w = (k == 8) ? 16'h8877 : (k == 20) ? 16'h4000 : 16'h0000;
        check($sformatf("pair res_data c%0d", k), 32'(res_data), 32'(exp_w));
      end
      in_valid = (k == 8);
      in_a = 16'h3E00;
      in_b = 16'h4000;
      res_byte = (k >= 19 && k % 2 == 1) ? 8'h40 : 8'h00;
      step();
    end

    // 8 pairs back-to-back: FIFO fills, in_ready drops at level 4, bus streams in order
    idx = 0;
    for (int k = 22; k < 41; k++) begin
      check($sformatf("burst fifo_level c%0d", k), 32'(fifo_level), 32'(lvl_tab[k-22]));
      check($sformatf("burst in_ready c%0d", k), 32'(in_ready), 32'(lvl_tab[k-22] != 4));
      if (k >= 25) exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
      else         exp_w = 16'h0000;
      check($sformatf("burst link_data c%0d", k), 32'(link_data), 32'(exp_w));
      check($sformatf("burst link_phase c%0d", k), 32'(link_phase), 32'(k % 2 == 0));
      check_rx(k, (k >= 34) && (k % 2 == 0));
      if (k % 2 == 0) check($sformatf("burst res_data c%0d", k), 32'(res_data), 32'h4000);
      in_valid = (idx < 8);
      in_a = 16'h1000 + 16'(idx);
      in_b = 16'h2000 + 16'(idx);
      acc = (idx < 8) && in_ready;
      if (acc) begin
        exp_q.push_back(in_a);
        exp_q.push_back(in_b);
      end
      res_byte = (k % 2 == 1) ? 8'h40 : 8'h00;
      step();
      if (acc) idx++;
    end
    check("burst all accepted", 32'(idx), 32'd8);

    // queue up pairs, then reset mid-stream with link_phase=0 and 2 pairs held
    for (int k = 41; k < 45; k++) begin
      exp_w = (k == 43) ? 16'h5000 : (k == 44) ? 16'h6000 : 16'h0000;
      check($sformatf("preq link_data c%0d", k), 32'(link_data), 32'(exp_w));
      check($sformatf("preq fifo_level c%0d", k), 32'(fifo_level), (k == 41) ? 32'h0 : (k == 44) ? 32'h2 : 32'h1);
      check_rx(k, k % 2 == 0);
      in_valid = 1'b1;
      in_a = 16'h5000 + 16'(k - 41);
      in_b = 16'h6000 + 16'(k - 41);
      res_byte = (k % 2 == 1) ? 8'h40 : 8'h00;
      step();
    end
    in_valid = 1'b0;
    check("preq c45 link_data", 32'(link_data), 32'h5001);
    check("preq c45 link_phase", 32'(link_phase), 32'h0);
    check("preq c45 fifo_level", 32'(fifo_level), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst link_data", 32'(link_data), 32'h0);
    check("midrst fifo_level", 32'(fifo_level), 32'h0);
    check("midrst link_phase", 32'(link_phase), 32'h0);
    step();
    check("midrst next res_valid", 32'(res_valid), 32'h0);
    check("midrst next res_tag", 32'(res_tag), 32'h0);
    check("midrst next res_data", 32'(res_data), 32'h0);
    check("midrst next link_data", 32'(link_data), 32'h0);
`ifdef LINK_PERF_CNT_EN
    check("midrst pair_cnt", 32'(pair_cnt), 32'h0);
    check("midrst idle_cnt", 32'(idle_cnt), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    res_byte = 8'h00;
    step();

    // after reset: stale tags gone, 3 new pairs issued and tagged
    for (int k = 1; k < 28; k++) begin
      case (k)
        13:      exp_w = 16'h7000;
        14:      exp_w = 16'h7100;
        15:      exp_w = 16'h7001;
        16:      exp_w = 16'h7101;
        17:      exp_w = 16'h7002;
        18:      exp_w = 16'h7102;
        default: exp_w = 16'h0000;
      endcase
      check($sformatf("post link_data c%0d", k), 32'(link_data), 32'(exp_w));
      check($sformatf("post link_phase c%0d", k), 32'(link_phase), 32'(k % 2 == 0));
      check($sformatf("post in_ready c%0d", k), 32'(in_ready), 32'h1);
      case (k)
        11, 15, 16: exp_w = 16'd1;
        12, 13, 14: exp_w = 16'd2;
        default:    exp_w = 16'd0;
      endcase
      check($sformatf("post fifo_level c%0d", k), 32'(fifo_level), 32'(exp_w));
      check_rx(k, (k == 22) || (k == 24) || (k == 26));
      if (k % 2 == 0) check($sformatf("post res_data c%0d", k), 32'(res_data), 32'h0);
`ifdef LINK_PERF_CNT_EN
      if (k == 1) begin
        check("perf pair_cnt c1", 32'(pair_cnt), 32'd0);
        check("perf idle_cnt c1", 32'(idle_cnt), 32'd1);
      end
      if (k == 20) begin
        check("perf pair_cnt c20", 32'(pair_cnt), 32'd3);
        check("perf idle_cnt c20", 32'(idle_cnt), 32'd7);
      end
`endif
      in_valid = (k >= 10) && (k <= 12);
      in_a = 16'h7000 + 16'(k - 10);
      in_b = 16'h7100 + 16'(k - 10);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
